// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT parameter defaults and the modular multiplier FSM state encoding
package ntt_pkg;
  localparam int LOGQ_DEF = 17;
  localparam int Q_DEF = 65537;
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, RED = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/modmul_seq_if.sv
// modmul_seq_if: operand/result valid-ready bundle of the modular multiplier
//   master drives in_valid/a/b/out_ready; slave drives in_ready/out_valid/p/busy
interface modmul_seq_if
  import ntt_pkg::*;
#(parameter int LOGQ = LOGQ_DEF);
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [LOGQ-1:0] a, b, p;
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, p, busy);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, p, busy);
endinterface

// File: rtl/modred_v2.sv
// modred_v2: combinational reduction of a 2*LOGQ-bit value modulo 2^(LOGQ-1)+1
//   x_i: value to reduce; r_o: x_i mod Q
module modred_v2 #(parameter int LOGQ = 17) (
  input  logic [2*LOGQ-1:0] x_i,
  output logic [LOGQ-1:0]   r_o
);
  localparam int K = LOGQ - 1;
  localparam logic [LOGQ+1:0] QM = (LOGQ+2)'((1 << K) + 1);
  logic [LOGQ+1:0] t, t1;
  // x = x0 + x1*2^K + x2*2^2K with 2^K == -1, so x == x0 - x1 + x2; +Q keeps it non-negative
  always_comb begin
    t = (LOGQ+2)'(x_i[K-1:0]) + (LOGQ+2)'(x_i[2*LOGQ-1:2*K]) + QM - (LOGQ+2)'(x_i[2*K-1:K]);
    t1 = t >= (QM << 1) ? t - (QM << 1) : t;
    r_o = LOGQ'(t1 >= QM ? t1 - QM : t1);
  end
endmodule

// File: rtl/modmul_seq.sv
// modmul_seq: iterative shift-and-add modular multiplier, p = (a*b) mod Q
//   clk/rst: clock and async active-high reset; bus: slave side of modmul_seq_if
module modmul_seq
  import ntt_pkg::*;
#(
  parameter int LOGQ = LOGQ_DEF,
  parameter int Q = Q_DEF
) (
  input logic clk,
  input logic rst,
  modmul_seq_if.slave bus
);
  localparam int CW = $clog2(LOGQ);
  if (Q != (1 << (LOGQ - 1)) + 1) begin : g_bad_q
    $error("Q does not match the modulus of modred_v2");
  end
  state_t st_q;
  logic [2*LOGQ-1:0] acc_q, acc_d, a_sh_q;
  logic [LOGQ-1:0] b_sh_q, p_q, red;
  logic [CW-1:0] cnt_q;
  logic out_valid_q, take;
  assign bus.in_ready = !rst && (st_q == IDLE || (st_q == DONE && bus.out_ready));
  assign take = bus.in_valid && bus.in_ready;
  assign acc_d = b_sh_q[0] ? acc_q + a_sh_q : acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.p = p_q;
  assign bus.busy = st_q == MUL || st_q == RED;
  modred_v2 #(.LOGQ(LOGQ)) u_red (.x_i(acc_q), .r_o(red));
  // the accept block comes last so a DONE-edge handoff overrides the return to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      out_valid_q <= 1'b0;
      p_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
    end else begin
      case (st_q)
        MUL: begin
          acc_q <= acc_d;
          a_sh_q <= a_sh_q << 1;
          b_sh_q <= b_sh_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(LOGQ - 1)) st_q <= RED;
        end
        RED: begin
          p_q <= red;
          out_valid_q <= 1'b1;
          st_q <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          st_q <= IDLE;
        end
        default: ;
      endcase
      if (take) begin
        a_sh_q <= (2*LOGQ)'(bus.a);
        b_sh_q <= bus.b;
        acc_q <= '0;
        cnt_q <= '0;
        st_q <= MUL;
      end
    end
  end
endmodule

// File: tb/tb_modmul_seq.sv
// tb_modmul_seq: randomized self-checking bench for modmul_seq against a transaction-level model
module tb_modmul_seq;
  localparam int LOGQ = 17;
  localparam longint QM = 65537;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  modmul_seq_if #(.LOGQ(LOGQ)) bus();
  modmul_seq #(.LOGQ(LOGQ), .Q(65537)) dut (.clk(clk), .rst(rst), .bus(bus));
  int passed = 0, total = 0, cyc = 0, acc_cyc = 0, done_cnt = 0;
  bit out_st = 0, took = 0;
  longint exp_p = 0;
  task automatic chk(input string n, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", n, act, req, cyc);
  endtask
  // One outstanding transaction: accepted at negedge acc_cyc, result visible LOGQ+2 negedges later,
  // held until consumed; a new pair is taken when idle or when the held result is being consumed.
  always @(negedge clk) begin : model
    bit ev;
    bit er;
    cyc++;
    took = 0;
    if (rst) out_st = 0;
    else begin
      ev = out_st && (cyc >= acc_cyc + LOGQ + 2);
      er = !out_st || (ev && bus.out_ready);
      chk("out_valid", bus.out_valid, ev);
      chk("in_ready", bus.in_ready, er);
      chk("busy", bus.busy, out_st && !ev);
      if (ev) chk("p", bus.p, exp_p);
      if (ev && bus.out_ready) begin
        out_st = 0;
        done_cnt++;
      end
      if (bus.in_valid && er) begin
        out_st = 1;
        acc_cyc = cyc;
        exp_p = (longint'(bus.a) * longint'(bus.b)) % QM;
        took = 1;
      end
    end
  end
  function automatic logic [LOGQ-1:0] rop();
    int r;
    r = $urandom_range(9, 0);
    return r == 0 ? '0 : r == 1 ? LOGQ'(65536) : LOGQ'($urandom_range(65536, 0));
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input longint a, input longint b);
    bus.a = LOGQ'(a);
    bus.b = LOGQ'(b);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (took) break;
    end
    if (!took) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!bus.out_valid) chk("out_timeout", 0, 1);
  endtask
  task automatic run_one(input longint a, input longint b, input longint expp, input string tag);
    int n;
    bus.out_ready = 1'b1;
    send(a, b);
    wait_out(n);
    chk({tag, "_latency"}, n, 18);
    chk({tag, "_p"}, bus.p, expp);
    tick();
  endtask
  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60 && out_st; i++) tick();
    chk("drain_idle", out_st, 0);
  endtask
  initial begin
    int n, d0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_p", bus.p, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", bus.in_ready, 1);
    run_one(3, 5, 15, "a3b5");
    run_one(65536, 65536, 1, "max_sq");
    run_one(65536, 2, 65535, "max_x2");
    run_one(0, 12345, 0, "zero");
    run_one(65536, 1, 65536, "max_x1");
    bus.out_ready = 1'b0;
    send(1234, 5678);
    wait_out(n);
    for (int i = 0; i < 10; i++) begin
      chk("bp_p", bus.p, 59730);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      if (i == 3) begin
        bus.a = 1;
        bus.b = 1;
        bus.in_valid = 1'b1;
      end
      if (i == 5) bus.in_valid = 1'b0;
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release", bus.out_valid, 0);
    chk("bp_busy", bus.busy, 0);
    chk("bp_idle_ready", bus.in_ready, 1);
    d0 = done_cnt;
    n = 0;
    bus.out_ready = 1'b1;
    bus.a = rop();
    bus.b = rop();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 * 19 + 100 && n < 20; i++) begin
      tick();
      if (took) begin
        n++;
        bus.a = rop();
        bus.b = rop();
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", n, 20);
    drain();
    chk("b2b_results", done_cnt - d0, 20);
    bus.out_ready = 1'b1;
    send(7, 9);
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_p", bus.p, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", bus.in_ready, 1);
    chk("postrst_valid", bus.out_valid, 0);
    chk("postrst_p", bus.p, 0);
    chk("postrst_busy", bus.busy, 0);
    run_one(7, 9, 63, "a7b9");
    d0 = done_cnt;
    n = 0;
    bus.a = rop();
    bus.b = rop();
    for (int i = 0; i < 60000 && n < 1000; i++) begin
      bus.out_ready = $urandom_range(9, 0) < 6;
      bus.in_valid = $urandom_range(9, 0) < 7;
      tick();
      if (took) begin
        n++;
        bus.a = rop();
        bus.b = rop();
      end
    end
    chk("rand_accepts", n, 1000);
    drain();
    chk("rand_results", done_cnt - d0, 1000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
